// File: rtl/pc_pkg.sv
// Shared types and constants for the front-end program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_RUN,
    PC_FAULT
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JAL,
    SRC_JALR,
    SRC_TRAP
  } pc_src_t;

  localparam int INSN_INC = 4;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect arbiter: computes candidate targets, picks the
// highest-priority request and flags a misaligned non-trap winner.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32
) (
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_pc,
  input  logic [XLEN-1:0] jal_imm,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output pc_src_t         src,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] trap_aligned;

  // Two's-complement adds: signed offsets wrap silently modulo 2^XLEN.
  assign br_target    = br_pc + br_imm;
  assign jal_target   = jal_pc + jal_imm;
  assign jalr_sum     = jalr_base + jalr_imm;
  assign jalr_target  = {jalr_sum[XLEN-1:1], 1'b0};
  assign trap_aligned = {trap_target[XLEN-1:2], 2'b00};

  always_comb begin
    src    = SRC_SEQ;
    target = '0;
    if (trap_valid) begin
      src    = SRC_TRAP;
      target = trap_aligned;
    end else if (jalr_valid) begin
      src    = SRC_JALR;
      target = jalr_target;
    end else if (jal_valid) begin
      src    = SRC_JAL;
      target = jal_target;
    end else if (br_valid && br_taken) begin
      src    = SRC_BR;
      target = br_target;
    end
  end

  // Trap targets are forced aligned, so only the other sources can fault.
  always_comb begin
    misaligned = 1'b0;
    if (src != SRC_SEQ && src != SRC_TRAP) begin
      if (IALIGN == 16) misaligned = target[0];
      else              misaligned = |target[1:0];
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset-vectored PC register with a
// valid/ready fetch handshake, prioritised redirects and misalign fault halt.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_pc_4,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_pc,
  input  logic [XLEN-1:0] jal_imm,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic            redirect,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect_d;
  logic            fault_d;
  logic [XLEN-1:0] fault_addr_d;

  pc_src_t         sel_src;
  logic [XLEN-1:0] sel_target;
  logic            sel_misaligned;

  pc_target_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_sel (
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .jal_valid   (jal_valid),
    .jal_pc      (jal_pc),
    .jal_imm     (jal_imm),
    .jalr_valid  (jalr_valid),
    .jalr_base   (jalr_base),
    .jalr_imm    (jalr_imm),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .src         (sel_src),
    .target      (sel_target),
    .misaligned  (sel_misaligned)
  );

  assign fetch_valid = (state_q == PC_RUN) && en;
  assign fetch_pc    = pc_q;
  assign fetch_pc_4  = pc_q + XLEN'(INSN_INC);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr;
    unique case (state_q)
      PC_IDLE, PC_RUN: begin
        if (state_q == PC_IDLE) state_d = PC_RUN;
        // A redirect overrides any handshake in the same cycle.
        if (sel_src != SRC_SEQ) begin
          if (sel_misaligned) begin
            state_d      = PC_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = sel_target;
          end else begin
            pc_d       = sel_target;
            redirect_d = 1'b1;
          end
        end else if (fetch_valid && fetch_ready) begin
          pc_d = pc_q + XLEN'(INSN_INC);
        end
      end
      PC_FAULT: begin
        // Only a trap can pull fetch out of a misalign halt.
        if (sel_src == SRC_TRAP) begin
          pc_d       = sel_target;
          redirect_d = 1'b1;
          state_d    = PC_RUN;
        end
      end
      default: state_d = PC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PC_IDLE;
      pc_q           <= RESET_VEC;
      redirect       <= 1'b0;
      misalign_fault <= 1'b0;
      fault_addr     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redirect       <= redirect_d;
      misalign_fault <= fault_d;
      fault_addr     <= fault_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit-aligned and a 16-bit-aligned instance
// share one stimulus stream; outputs are sampled on the falling edge.
module tb_pc_gen;

  localparam int          XLEN = 64;
  localparam logic [63:0] RV   = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            fetch_ready;
  logic            br_valid, br_taken;
  logic [XLEN-1:0] br_pc, br_imm;
  logic            jal_valid;
  logic [XLEN-1:0] jal_pc, jal_imm;
  logic            jalr_valid;
  logic [XLEN-1:0] jalr_base, jalr_imm;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;

  logic            fetch_valid, redirect, misalign_fault;
  logic [XLEN-1:0] fetch_pc, fetch_pc_4, fault_addr;
  logic            fetch_valid_16, redirect_16, misalign_fault_16;
  logic [XLEN-1:0] fetch_pc_16, fetch_pc_4_16, fault_addr_16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .IALIGN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_pc_4(fetch_pc_4),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
    .jal_valid(jal_valid), .jal_pc(jal_pc), .jal_imm(jal_imm),
    .jalr_valid(jalr_valid), .jalr_base(jalr_base), .jalr_imm(jalr_imm),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redirect(redirect), .misalign_fault(misalign_fault), .fault_addr(fault_addr)
  );

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .IALIGN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fetch_valid(fetch_valid_16), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc_16), .fetch_pc_4(fetch_pc_4_16),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
    .jal_valid(jal_valid), .jal_pc(jal_pc), .jal_imm(jal_imm),
    .jalr_valid(jalr_valid), .jalr_base(jalr_base), .jalr_imm(jalr_imm),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redirect(redirect_16), .misalign_fault(misalign_fault_16), .fault_addr(fault_addr_16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_imm = '0;
    jal_valid = 1'b0; jal_pc = '0; jal_imm = '0;
    jalr_valid = 1'b0; jalr_base = '0; jalr_imm = '0;
    trap_valid = 1'b0; trap_target = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; fetch_ready = 1'b1;
    clear_req();
    step(); step();
    chk("rst_pc",        fetch_pc,       RV);
    chk("rst_pc4",       fetch_pc_4,     RV + 64'd4);
    chk("rst_valid",     fetch_valid,    1'b0);
    chk("rst_redirect",  redirect,       1'b0);
    chk("rst_fault",     misalign_fault, 1'b0);
    chk("rst_faddr",     fault_addr,     64'h0);

    rst_n = 1'b1;
    #1 chk("idle_valid", fetch_valid, 1'b0);
    step(); chk("seq0_pc", fetch_pc, 64'h8000_0000); chk("seq0_valid", fetch_valid, 1'b1);
    step(); chk("seq1_pc", fetch_pc, 64'h8000_0004);
    step(); chk("seq2_pc", fetch_pc, 64'h8000_0008);

    // Trap redirect to 0x100 while a handshake is also happening.
    trap_valid = 1'b1; trap_target = 64'h100;
    step(); clear_req();
    chk("trap100_pc", fetch_pc, 64'h100); chk("trap100_redir", redirect, 1'b1);
    fetch_ready = 1'b0;
    step(); chk("stall1_pc", fetch_pc, 64'h100); chk("stall1_redir", redirect, 1'b0);
    step(); chk("stall2_pc", fetch_pc, 64'h100);
    step(); chk("stall3_pc", fetch_pc, 64'h100); chk("stall3_valid", fetch_valid, 1'b1);
    fetch_ready = 1'b1;
    step(); chk("release_pc", fetch_pc, 64'h104);

    // JALR beats a taken branch; bit 0 of the JALR sum is cleared.
    jalr_valid = 1'b1; jalr_base = 64'h2001; jalr_imm = 64'h0;
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 64'h40; br_imm = 64'h10;
    step(); clear_req();
    chk("jalr_pc16",    fetch_pc_16, 64'h2000); chk("jalr_redir16", redirect_16, 1'b1);
    chk("jalr_pc32",    fetch_pc,    64'h2000); chk("jalr_redir32", redirect,    1'b1);

    en = 1'b0;
    step(); chk("en0_valid", fetch_valid, 1'b0); chk("en0_pc", fetch_pc, 64'h2000);
    en = 1'b1;
    step(); chk("en1_pc", fetch_pc, 64'h2004);

    // JAL to 0x206: misaligned for 32-bit, legal for 16-bit alignment.
    jal_valid = 1'b1; jal_pc = 64'h200; jal_imm = 64'h6;
    step(); clear_req();
    chk("jal_fault32", misalign_fault, 1'b1);
    chk("jal_faddr32", fault_addr,     64'h206);
    chk("jal_valid32", fetch_valid,    1'b0);
    chk("jal_pc32",    fetch_pc,       64'h2004);
    chk("jal_redir32", redirect,       1'b0);
    chk("jal_pc16",    fetch_pc_16,    64'h206);
    chk("jal_redir16", redirect_16,    1'b1);

    br_valid = 1'b1; br_taken = 1'b1; br_pc = 64'h40; br_imm = 64'h10;
    step(); clear_req();
    chk("fault_br_pc",    fetch_pc,       64'h2004);
    chk("fault_br_redir", redirect,       1'b0);
    chk("fault_br_pulse", misalign_fault, 1'b0);
    chk("fault_br_faddr", fault_addr,     64'h206);
    chk("fault_br_valid", fetch_valid,    1'b0);

    trap_valid = 1'b1; trap_target = 64'h1003;
    step(); clear_req();
    chk("trap_out_pc",    fetch_pc,    64'h1000);
    chk("trap_out_redir", redirect,    1'b1);
    chk("trap_out_valid", fetch_valid, 1'b1);
    chk("trap_out_pc16",  fetch_pc_16, 64'h1000);

    // Branch to 0x42: faults only under 32-bit alignment.
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 64'h40; br_imm = 64'h2;
    step(); clear_req();
    chk("br42_fault32", misalign_fault,    1'b1);
    chk("br42_faddr32", fault_addr,        64'h42);
    chk("br42_pc32",    fetch_pc,          64'h1000);
    chk("br42_pc16",    fetch_pc_16,       64'h42);
    chk("br42_fault16", misalign_fault_16, 1'b0);

    // Branch to 0x51 via a negative offset: odd target faults the 16-bit unit.
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 64'h60; br_imm = 64'hFFFF_FFFF_FFFF_FFF1;
    step(); clear_req();
    chk("br51_fault16", misalign_fault_16, 1'b1);
    chk("br51_faddr16", fault_addr_16,     64'h51);
    chk("br51_pc16",    fetch_pc_16,       64'h42);

    trap_valid = 1'b1; trap_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); clear_req();
    chk("wrap_pc",    fetch_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4",   fetch_pc_4,  64'h0);
    chk("wrap_pc16",  fetch_pc_16, 64'hFFFF_FFFF_FFFF_FFFC);
    br_valid = 1'b1; br_taken = 1'b0; br_pc = 64'h40; br_imm = 64'h10;
    step(); clear_req();
    chk("wrap_next_pc", fetch_pc, 64'h0);
    chk("wrap_redir",   redirect, 1'b0);

    trap_valid = 1'b1; trap_target = 64'h500;
    step(); clear_req();
    chk("pre_rst_pc", fetch_pc, 64'h500);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pc",    fetch_pc,    RV);
    chk("async_rst_valid", fetch_valid, 1'b0);
    chk("async_rst_redir", redirect,    1'b0);
    step(); rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
